// File: rtl/mul_seq_int.sv
// Iterative shift-add multiplier: one operand pair per valid/ready transaction, RADIX_BITS multiplier bits per cycle.
// Define MUL_SEQ_SIGNED_EN to honour signed_mode (two's-complement operands); otherwise all products are unsigned.
module mul_seq_int #(
    parameter int WIDTH      = 16,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_lo,
    output logic [WIDTH-1:0] p_hi
);

    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic                 accept;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   res_fix;
    logic [2*WIDTH-1:0]   pp_sum;
    logic [2*WIDTH-1:0]   pp_term [RADIX_BITS];

    assign accept = (state_q == IDLE) && in_valid && in_ready_q;

`ifdef MUL_SEQ_SIGNED_EN
    logic neg_q, neg_d;
    logic a_neg, b_neg;

    // Magnitudes fit WIDTH bits unsigned, including the most negative value.
    always_comb begin
        a_neg   = signed_mode & a[WIDTH-1];
        b_neg   = signed_mode & b[WIDTH-1];
        a_mag   = a_neg ? (~a + 1'b1) : a;
        b_mag   = b_neg ? (~b + 1'b1) : b;
        neg_d   = accept ? (a_neg ^ b_neg) : neg_q;
        res_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`else
    logic sm_unused;
    assign sm_unused = signed_mode;

    always_comb begin
        a_mag   = a;
        b_mag   = b;
        res_fix = acc_q;
    end
`endif

    // Each consumed multiplier bit selects a copy of the aligned multiplicand.
    generate
        for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
            assign pp_term[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            pp_sum = pp_sum + pp_term[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        p_d         = p_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                    mcand_d    = {{WIDTH{1'b0}}, a_mag};
                    mplier_d   = b_mag;
                    acc_d      = '0;
                    cnt_d      = '0;
                end
            end
            BUSY: begin
                // Counter reaching N marks the extra sign-fix cycle before DONE.
                if (cnt_q == CW'(N)) begin
                    p_d         = res_fix;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d    = acc_q + pp_sum;
                    mcand_d  = mcand_q << RADIX_BITS;
                    mplier_d = mplier_q >> RADIX_BITS;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            p_q         <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            p_q         <= p_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p_lo      = p_q[WIDTH-1:0];
    assign p_hi      = p_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_seq_int.sv
// Directed bench for mul_seq_int: radix-1 and radix-4 instances, WIDTH=16.
// Expected values for signed vectors follow MUL_SEQ_SIGNED_EN as seen by this compile.
module tb_mul_seq_int;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        sm = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        in_valid4 = 1'b0;
    logic        in_ready1, out_valid1, in_ready4, out_valid4;
    logic [15:0] p_lo1, p_hi1, p_lo4, p_hi4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_int #(.WIDTH(16), .RADIX_BITS(1)) u_r1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a_in), .b(b_in), .signed_mode(sm), .out_valid(out_valid1),
        .out_ready(out_ready), .p_lo(p_lo1), .p_hi(p_hi1)
    );

    mul_seq_int #(.WIDTH(16), .RADIX_BITS(4)) u_r4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a_in), .b(b_in), .signed_mode(sm), .out_valid(out_valid4),
        .out_ready(out_ready), .p_lo(p_lo4), .p_hi(p_hi4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction on the selected instance; lat = edges from accept to out_valid, -1 on timeout.
    task automatic run_txn(input int sel, input logic [15:0] ai, input logic [15:0] bi,
                           input logic smi, output int lat, output logic [31:0] prod);
        int k;
        k = 0;
        while (((sel == 4) ? in_ready4 : in_ready1) !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        a_in = ai;
        b_in = bi;
        sm   = smi;
        if (sel == 4) in_valid4 = 1'b1;
        else          in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        a_in = 16'hDEAD;
        b_in = 16'hBEEF;
        sm   = ~smi;
        lat  = 0;
        while (((sel == 4) ? out_valid4 : out_valid1) !== 1'b1 && lat < 60) begin
            step();
            lat++;
        end
        if (lat >= 60) lat = -1;
        prod = (sel == 4) ? {p_hi4, p_lo4} : {p_hi1, p_lo1};
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({in_ready1, out_valid1, in_ready4, out_valid4} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {in_ready1, out_valid1, in_ready4, out_valid4});
        end
        checks++;
        if ({p_hi1, p_lo1, p_hi4, p_lo4} !== 64'h0) begin
            errors++;
            $display("FAIL reset_product: got %h expected 0", {p_hi1, p_lo1, p_hi4, p_lo4});
        end
        rst = 1'b0;
        step();
        step();
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b expected 1", in_ready1);
        end
        $display("test_reset done");
    endtask

    task automatic test_unsigned();
        int lat;
        logic [31:0] prod;
        run_txn(1, 16'd3, 16'd5, 1'b0, lat, prod);
        $display("txn r1 a=0003 b=0005 u lat=%0d p=%h", lat, prod);
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL u_3x5_latency: got %0d expected 17", lat);
        end
        checks++;
        if (prod !== 32'h0000_000F) begin
            errors++;
            $display("FAIL u_3x5_product: got %h expected 0000000f", prod);
        end
        run_txn(1, 16'hFFFF, 16'hFFFF, 1'b0, lat, prod);
        $display("txn r1 a=ffff b=ffff u lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== 32'hFFFE_0001) begin
            errors++;
            $display("FAIL u_max_product: got %h expected fffe0001", prod);
        end
        run_txn(1, 16'h1234, 16'h0010, 1'b0, lat, prod);
        $display("txn r1 a=1234 b=0010 u lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== 32'h0001_2340) begin
            errors++;
            $display("FAIL u_1234x10_product: got %h expected 00012340", prod);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] prod;
        logic [31:0] exp_m3x7, exp_m3xm5;
`ifdef MUL_SEQ_SIGNED_EN
        exp_m3x7  = 32'hFFFF_FFEB;
        exp_m3xm5 = 32'h0000_000F;
`else
        exp_m3x7  = 32'h0006_FFEB;
        exp_m3xm5 = 32'hFFF8_000F;
`endif
        run_txn(1, 16'h8000, 16'h8000, 1'b1, lat, prod);
        $display("txn r1 a=8000 b=8000 s lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== 32'h4000_0000) begin
            errors++;
            $display("FAIL s_min_x_min: got %h expected 40000000", prod);
        end
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL s_latency: got %0d expected 17", lat);
        end
        run_txn(1, 16'hFFFD, 16'h0007, 1'b1, lat, prod);
        $display("txn r1 a=fffd b=0007 s lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== exp_m3x7) begin
            errors++;
            $display("FAIL s_m3x7: got %h expected %h", prod, exp_m3x7);
        end
        run_txn(1, 16'h0007, 16'hFFFD, 1'b1, lat, prod);
        $display("txn r1 a=0007 b=fffd s lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== exp_m3x7) begin
            errors++;
            $display("FAIL s_7xm3: got %h expected %h", prod, exp_m3x7);
        end
        run_txn(1, 16'hFFFD, 16'hFFFB, 1'b1, lat, prod);
        $display("txn r1 a=fffd b=fffb s lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== exp_m3xm5) begin
            errors++;
            $display("FAIL s_m3xm5: got %h expected %h", prod, exp_m3xm5);
        end
        run_txn(1, 16'hFFFD, 16'h0007, 1'b0, lat, prod);
        $display("txn r1 a=fffd b=0007 u lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== 32'h0006_FFEB) begin
            errors++;
            $display("FAIL u_fffdx7: got %h expected 0006ffeb", prod);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int lat;
        k = 0;
        while (in_ready1 !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        a_in = 16'h00FF;
        b_in = 16'h0101;
        sm = 1'b0;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        k = 0;
        while (out_valid1 !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({out_valid1, in_ready1, p_hi1, p_lo1} !== {2'b10, 32'h0000_FFFF}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b p=%h expected ov=1 ir=0 p=0000ffff",
                         i, out_valid1, in_ready1, {p_hi1, p_lo1});
            end
            step();
        end
        $display("txn r1 a=00ff b=0101 held 10 cycles p=%h", {p_hi1, p_lo1});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if ({out_valid1, in_ready1} !== 2'b01) begin
            errors++;
            $display("FAIL release_handshake: got ov=%b ir=%b expected ov=0 ir=1", out_valid1, in_ready1);
        end
        a_in = 16'h0100;
        b_in = 16'h0101;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        checks++;
        if (in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ir=%b expected 0", in_ready1);
        end
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 60) begin
            step();
            lat++;
        end
        $display("txn r1 a=0100 b=0101 b2b lat=%0d p=%h", lat, {p_hi1, p_lo1});
        checks++;
        if (lat != 17 || {p_hi1, p_lo1} !== 32'h0001_0100) begin
            errors++;
            $display("FAIL b2b_result: got lat=%0d p=%h expected lat=17 p=00010100", lat, {p_hi1, p_lo1});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int k;
        int lat;
        logic seen_valid;
        logic seen_ready;
        logic [31:0] prod;
        k = 0;
        while (in_ready1 !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        a_in = 16'h1111;
        b_in = 16'h2222;
        sm = 1'b0;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({out_valid1, in_ready1, p_hi1, p_lo1} !== 34'h0) begin
            errors++;
            $display("FAIL abort_outputs: got ov=%b ir=%b p=%h expected all 0",
                     out_valid1, in_ready1, {p_hi1, p_lo1});
        end
        seen_valid = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid1 === 1'b1) seen_valid = 1'b1;
            if (in_ready1 === 1'b1) seen_ready = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_output: got out_valid seen=%b expected 0", seen_valid);
        end
        checks++;
        if (seen_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_ready: got seen=%b expected 1", seen_ready);
        end
        run_txn(1, 16'd2, 16'd9, 1'b0, lat, prod);
        $display("txn r1 a=0002 b=0009 after abort lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== 32'h0000_0012 || lat != 17) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d p=%h expected lat=17 p=00000012", lat, prod);
        end
    endtask

    task automatic test_radix4();
        int lat;
        logic [31:0] prod;
        logic [31:0] exp_m3x7;
`ifdef MUL_SEQ_SIGNED_EN
        exp_m3x7 = 32'hFFFF_FFEB;
`else
        exp_m3x7 = 32'h0006_FFEB;
`endif
        run_txn(4, 16'h1234, 16'h0010, 1'b0, lat, prod);
        $display("txn r4 a=1234 b=0010 u lat=%0d p=%h", lat, prod);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL r4_latency: got %0d expected 5", lat);
        end
        checks++;
        if (prod !== 32'h0001_2340) begin
            errors++;
            $display("FAIL r4_1234x10: got %h expected 00012340", prod);
        end
        run_txn(4, 16'hFFFF, 16'hFFFF, 1'b0, lat, prod);
        $display("txn r4 a=ffff b=ffff u lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== 32'hFFFE_0001) begin
            errors++;
            $display("FAIL r4_max: got %h expected fffe0001", prod);
        end
        run_txn(4, 16'h00FF, 16'h0F0F, 1'b0, lat, prod);
        $display("txn r4 a=00ff b=0f0f u lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== 32'h000E_FFF1) begin
            errors++;
            $display("FAIL r4_ffx0f0f: got %h expected 000efff1", prod);
        end
        run_txn(4, 16'hFFFD, 16'h0007, 1'b1, lat, prod);
        $display("txn r4 a=fffd b=0007 s lat=%0d p=%h", lat, prod);
        checks++;
        if (prod !== exp_m3x7) begin
            errors++;
            $display("FAIL r4_m3x7: got %h expected %h", prod, exp_m3x7);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_abort();
        test_radix4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_int.md
# mul_seq_int

Sequential, parametrised integer multiplier for the arithmetic benchmark set. It is the iterative successor to the combinational 16-bit shift-add multiplier. It accepts one operand pair per transaction over a valid/ready handshake and retires `RADIX_BITS` multiplier bits per cycle through a shift-add datapath. It returns the full 2·`WIDTH`-bit product, with optional signed mode. It serves benchmarks that need a pipelined-resource multiplier with flow control instead of a flat adder chain.

## Interface
- `WIDTH`, default 16: operand width. Legal range is ≥2.
- `RADIX_BITS`, default 1: multiplier bits consumed per iteration. Must divide `WIDTH`. Iteration count `N = WIDTH/RADIX_BITS`.
- `clk`, input, 1: clock. All logic is on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept operands.
- `a`, input, `WIDTH`: multiplicand.
- `b`, input, `WIDTH`: multiplier.
- `signed_mode`, input, 1: treat `a`/`b` as two's complement. Sampled with the operands.
- `out_valid`, output, 1: product valid.
- `out_ready`, input, 1: consumer accepts product.
- `p_lo`, output, `WIDTH`: product bits [`WIDTH`-1:0].
- `p_hi`, output, `WIDTH`: product bits [2·`WIDTH`-1:`WIDTH`].

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `a`, `b` and `signed_mode`, clear the accumulator and iteration counter, then go to BUSY.
- BUSY:
  - Each cycle, add `a_mag × b_mag[RADIX_BITS-1:0]` (zero-extended partial product) into the accumulator.
  - Shift the multiplier right by `RADIX_BITS`. Increment the counter.
  - After iteration N, go to DONE.
- Signed handling:
  - `a_mag`/`b_mag` are the absolute values when the latched `signed_mode`=1, otherwise the raw operands.
  - Result sign = `a[WIDTH-1] ^ b[WIDTH-1]` when signed.
  - On entry to DONE, the 2·`WIDTH` result is two's-complement negated if the sign is negative.
  - Magnitude of -2^(`WIDTH`-1) is 2^(`WIDTH`-1), held unsigned in `WIDTH` bits, so no overflow occurs.
- DONE:
  - `out_valid`=1. `p_hi`/`p_lo` are held stable.
  - On `out_valid`&`out_ready`, go to IDLE.
- Only one transaction is in flight. `in_ready`=0 in BUSY and DONE. Input changes outside the accept cycle are ignored.
- `p_lo` equals the low `WIDTH` bits of the product in both modes.
- Reset values: `in_ready`=0 during the reset cycle, then 1. `out_valid`=0. `p_lo`=`p_hi`=0. Counter and accumulator are 0.

## Timing
- Accept on edge T. `out_valid` rises after edge T+N+1, so the product is visible for the full cycle following edge T+N+1. Latency is N+1 cycles, where the extra cycle is the sign-fix in the DONE transition.
- `out_valid` stays high with a stable product until the handshake. Arbitrary `out_ready` backpressure is allowed.
- After the output handshake on edge D, `in_ready`=1 from edge D. The next accept is no earlier than edge D+1. There is no same-cycle output/input overlap.
- `rst` asserted in any state (mid-BUSY included) aborts the transaction. Outputs return to reset values after that edge. No partial result is ever presented.
- `rst` dominates a simultaneous `in_valid` or `out_ready` handshake.
- Throughput is one product per N+3 cycles at best.

## Configuration
- `MUL_SEQ_SIGNED_EN`:
  - Defined: `signed_mode` is honoured as above.
  - Undefined: `signed_mode` is ignored, all operations are unsigned, and the magnitude and negation logic is not synthesised.
  - Latency is N+1 in both builds, so timing is identical.

## Test plan
- `WIDTH`=16, `RADIX_BITS`=1, unsigned, a=3, b=5, `out_ready`=1 → `out_valid` exactly 17 cycles after accept; `p_hi`=0x0000, `p_lo`=0x000F.
- Unsigned a=0xFFFF, b=0xFFFF → `p_hi`=0xFFFE, `p_lo`=0x0001.
- Signed (macro defined), a=0x8000, b=0x8000 → `p_hi`=0x4000, `p_lo`=0x0000.
- Signed a=0xFFFD (-3), b=0x0007 → `p_hi`=0xFFFF, `p_lo`=0xFFEB.
- Same test with the macro undefined → `p_hi`=0x0006, `p_lo`=0xFFEB.
- Hold `out_ready`=0 for 10 cycles after `out_valid` → product stable and `in_ready`=0 throughout. Then assert `out_ready` for 1 cycle → `out_valid`=0 and `in_ready`=1 after the edge. A back-to-back second pair is accepted the next cycle.
- Assert `rst` for one cycle on BUSY iteration 7 → `out_valid` never rises for that pair and `in_ready`=1 after reset. A new pair a=2, b=9 then returns `p_lo`=0x0012.
- `RADIX_BITS`=4, a=0x1234, b=0x0010 → latency 5 cycles; `p_hi`=0x0001, `p_lo`=0x2340.
